// File: rtl/shapool_job_ctrl.sv
// rtl/shapool_job_ctrl.sv - job sequencer for one shapool instance: accept, prime, run, report
module shapool_job_ctrl #(
    parameter int unsigned RESET_CYCLES  = 2,
    parameter int unsigned TIMEOUT_WIDTH = 38
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_sha_state,
    input  logic [95:0]  job_message_head,
    input  logic [15:0]  job_difficulty_bm,
    input  logic [7:0]   job_nonce_start_MSB,
    input  logic         cancel,
    output logic         pool_reset,
    output logic [255:0] pool_sha_state,
    output logic [95:0]  pool_message_head,
    output logic [15:0]  pool_difficulty_bm,
    output logic [7:0]   pool_nonce_start_MSB,
    input  logic         pool_success,
    input  logic [31:0]  pool_nonce,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         result_found,
    output logic         result_cancelled,
    output logic [31:0]  result_nonce,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = TIMEOUT_WIDTH'(1);

    logic [1:0]               state_q, state_d;
    logic [RC_W-1:0]          rcnt_q, rcnt_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d, tmo_inc;
    logic                     found_q, found_d;
    logic                     canc_q, canc_d;
    logic [31:0]              nonce_q, nonce_d;
    logic                     load_params;

    assign tmo_inc = tmo_q + TMO_ONE;

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        tmo_d       = tmo_q;
        found_d     = found_q;
        canc_d      = canc_q;
        nonce_d     = nonce_q;
        load_params = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    load_params = 1'b1;
                    rcnt_d      = '0;
                    found_d     = 1'b0;
                    canc_d      = 1'b0;
                    nonce_d     = '0;
                    state_d     = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (cancel) begin
                    canc_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (rcnt_q == RC_LAST) begin
                    tmo_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                tmo_d = tmo_inc;
                // Cancel outranks success, which outranks exhaustion.
                if (cancel) begin
                    canc_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (pool_success) begin
                    found_d = 1'b1;
                    nonce_d = pool_nonce;
                    state_d = ST_DONE;
                end else if (tmo_inc == '1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    found_d = 1'b0;
                    canc_d  = 1'b0;
                    nonce_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= ST_IDLE;
            rcnt_q               <= '0;
            tmo_q                <= '0;
            found_q              <= 1'b0;
            canc_q               <= 1'b0;
            nonce_q              <= '0;
            pool_sha_state       <= '0;
            pool_message_head    <= '0;
            pool_difficulty_bm   <= '0;
            pool_nonce_start_MSB <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            tmo_q   <= tmo_d;
            found_q <= found_d;
            canc_q  <= canc_d;
            nonce_q <= nonce_d;
            if (load_params) begin
                pool_sha_state       <= job_sha_state;
                pool_message_head    <= job_message_head;
                pool_difficulty_bm   <= job_difficulty_bm;
                pool_nonce_start_MSB <= job_nonce_start_MSB;
            end
        end
    end

    assign job_ready        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign pool_reset       = (state_q != ST_RUN);
    assign result_valid     = (state_q == ST_DONE);
    assign result_found     = found_q;
    assign result_cancelled = canc_q;
    assign result_nonce     = nonce_q;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// tb/tb_shapool_job_ctrl.sv - scoreboard bench for shapool_job_ctrl
module tb_shapool_job_ctrl;

    typedef struct packed {
        logic        found;
        logic        canc;
        logic [31:0] nonce;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_sha_state;
    logic [95:0]  job_message_head;
    logic [15:0]  job_difficulty_bm;
    logic [7:0]   job_nonce_start_MSB;
    logic         cancel;
    logic         pool_reset;
    logic [255:0] pool_sha_state;
    logic [95:0]  pool_message_head;
    logic [15:0]  pool_difficulty_bm;
    logic [7:0]   pool_nonce_start_MSB;
    logic         pool_success;
    logic [31:0]  pool_nonce;
    logic         result_valid;
    logic         result_ready;
    logic         result_found;
    logic         result_cancelled;
    logic [31:0]  result_nonce;
    logic         busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    localparam logic [255:0] SHA_A = 256'hdc6a3b8d_0e3b1f2a_9c4d5e6f_7a8b9c0d_1e2f3a4b_5c6d7e8f_90a1b2c3_fc48d2df;
    localparam logic [255:0] SHA_B = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    shapool_job_ctrl #(.RESET_CYCLES(2), .TIMEOUT_WIDTH(6)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_sha_state(job_sha_state), .job_message_head(job_message_head),
        .job_difficulty_bm(job_difficulty_bm), .job_nonce_start_MSB(job_nonce_start_MSB),
        .cancel(cancel), .pool_reset(pool_reset),
        .pool_sha_state(pool_sha_state), .pool_message_head(pool_message_head),
        .pool_difficulty_bm(pool_difficulty_bm), .pool_nonce_start_MSB(pool_nonce_start_MSB),
        .pool_success(pool_success), .pool_nonce(pool_nonce),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_found(result_found), .result_cancelled(result_cancelled),
        .result_nonce(result_nonce), .busy(busy)
    );

    always #5 clk = ~clk;

    // Offers a job at a negedge; returns at the negedge after the accepting edge (1st PRIME cycle).
    task automatic send_job(input logic [255:0] sha, input logic [95:0] head,
                            input logic [15:0] bm, input logic [7:0] msb);
        job_sha_state       = sha;
        job_message_head    = head;
        job_difficulty_bm   = bm;
        job_nonce_start_MSB = msb;
        job_valid           = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({job_ready, pool_reset, result_valid, busy} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_idle: got rdy/prst/rv/busy=%b want 1100", {job_ready, pool_reset, result_valid, busy});
        end
        n_cmp++;
        if ({pool_sha_state, pool_difficulty_bm, result_nonce, result_found, result_cancelled} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: pool/result registers not zero (sha=%h nonce=%h)", pool_sha_state, result_nonce);
        end
    endtask

    task automatic test_found();
        bit   to;
        exp_t e;
        send_job(SHA_A, 96'h1111_2222_3333_4444_5555_6666, 16'h0007, 8'h5a);
        n_cmp++;
        if (pool_sha_state !== SHA_A || pool_difficulty_bm !== 16'h0007 ||
            pool_message_head !== 96'h1111_2222_3333_4444_5555_6666 || pool_nonce_start_MSB !== 8'h5a) begin
            n_bad++;
            $display("FAIL found_params: sha=%h bm=%h msb=%h", pool_sha_state, pool_difficulty_bm, pool_nonce_start_MSB);
        end
        n_cmp++;
        if ({job_ready, busy, pool_reset} !== 3'b011) begin
            n_bad++;
            $display("FAIL found_prime1: rdy/busy/prst=%b want 011", {job_ready, busy, pool_reset});
        end
        @(negedge clk);
        n_cmp++;
        if (pool_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL found_prime2: pool_reset=%b want 1", pool_reset);
        end
        @(negedge clk);
        n_cmp++;
        if (pool_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL found_run: pool_reset=%b want 0", pool_reset);
        end
        pool_success = 1'b1;
        pool_nonce   = 32'h0000_0123;
        sb.push_back('{found: 1'b1, canc: 1'b0, nonce: 32'h0000_0123});
        @(negedge clk);
        pool_success = 1'b0;
        pool_nonce   = 32'hdead_beef;
        n_cmp++;
        if (result_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL found_latency: result_valid=%b want 1 one cycle after success", result_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({result_found, result_cancelled, result_nonce} !== {e.found, e.canc, e.nonce}) begin
            n_bad++;
            $display("FAIL found_result: got f=%b c=%b n=%h want f=%b c=%b n=%h",
                     result_found, result_cancelled, result_nonce, e.found, e.canc, e.nonce);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({result_valid, result_found, result_cancelled, result_nonce, pool_reset} !== {1'b1, e.found, e.canc, e.nonce, 1'b1}) begin
                n_bad++;
                $display("FAIL found_hold%0d: rv=%b f=%b n=%h prst=%b", i, result_valid, result_found, result_nonce, pool_reset);
            end
        end
        handshake();
        n_cmp++;
        if ({result_valid, busy, job_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL found_release: rv/busy/rdy=%b want 001", {result_valid, busy, job_ready});
        end
        wait_valid(1, to);
    endtask

    task automatic test_exhaust();
        bit   to;
        int   run_cycles;
        exp_t e;
        send_job(SHA_B, 96'h0, 16'h00ff, 8'h01);
        sb.push_back('{found: 1'b0, canc: 1'b0, nonce: 32'h0});
        run_cycles = 0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!pool_reset) run_cycles++;
            @(negedge clk);
            if (result_valid) begin
                to = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL exhaust_timeout: no result within 200 cycles");
        end
        n_cmp++;
        if (run_cycles != 63) begin
            n_bad++;
            $display("FAIL exhaust_cycles: run cycles=%0d want 63", run_cycles);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({result_found, result_cancelled, result_nonce} !== {e.found, e.canc, e.nonce}) begin
            n_bad++;
            $display("FAIL exhaust_result: got f=%b c=%b n=%h want f=%b c=%b n=%h",
                     result_found, result_cancelled, result_nonce, e.found, e.canc, e.nonce);
        end
        handshake();
    endtask

    task automatic test_cancel();
        exp_t e;
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++;
        if ({busy, result_valid, job_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL cancel_idle: busy/rv/rdy=%b want 001", {busy, result_valid, job_ready});
        end
        send_job(SHA_A, 96'h0, 16'h0001, 8'h02);
        @(negedge clk);
        cancel = 1'b1;
        sb.push_back('{found: 1'b0, canc: 1'b1, nonce: 32'h0});
        @(negedge clk);
        cancel = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if ({result_valid, pool_reset, result_found, result_cancelled, result_nonce} !== {2'b11, e.found, e.canc, e.nonce}) begin
            n_bad++;
            $display("FAIL cancel_prime: rv=%b prst=%b f=%b c=%b n=%h", result_valid, pool_reset,
                     result_found, result_cancelled, result_nonce);
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n_cmp++;
        if ({result_valid, result_cancelled} !== 2'b11) begin
            n_bad++;
            $display("FAIL cancel_done: rv/c=%b want 11", {result_valid, result_cancelled});
        end
        handshake();
    endtask

    task automatic test_priority();
        exp_t e;
        send_job(SHA_B, 96'h7, 16'h0003, 8'h03);
        repeat (3) @(negedge clk);
        cancel       = 1'b1;
        pool_success = 1'b1;
        pool_nonce   = 32'h0000_0abc;
        sb.push_back('{found: 1'b0, canc: 1'b1, nonce: 32'h0});
        @(negedge clk);
        cancel       = 1'b0;
        pool_success = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if ({result_valid, result_found, result_cancelled, result_nonce} !== {1'b1, e.found, e.canc, e.nonce}) begin
            n_bad++;
            $display("FAIL priority: rv=%b f=%b c=%b n=%h want c=1 f=0 n=0", result_valid,
                     result_found, result_cancelled, result_nonce);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit   to;
        exp_t e;
        send_job(SHA_A, 96'h9, 16'h000f, 8'h04);
        repeat (2) @(negedge clk);
        job_sha_state     = SHA_B;
        job_difficulty_bm = 16'hbeef;
        job_valid         = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (job_ready !== 1'b0 || pool_sha_state !== SHA_A || pool_difficulty_bm !== 16'h000f) begin
            n_bad++;
            $display("FAIL b2b_hold: rdy=%b bm=%h want rdy=0 bm=000f", job_ready, pool_difficulty_bm);
        end
        pool_success = 1'b1;
        pool_nonce   = 32'h1234_5678;
        sb.push_back('{found: 1'b1, canc: 1'b0, nonce: 32'h1234_5678});
        wait_valid(4, to);
        pool_success = 1'b0;
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL b2b_timeout: no result");
        end
        e = sb.pop_front();
        n_cmp++;
        if ({result_found, result_nonce, pool_sha_state} !== {e.found, e.nonce, SHA_A}) begin
            n_bad++;
            $display("FAIL b2b_result: f=%b n=%h", result_found, result_nonce);
        end
        handshake();
        @(negedge clk);
        job_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || pool_sha_state !== SHA_B || pool_difficulty_bm !== 16'hbeef) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b bm=%h want busy=1 bm=beef", busy, pool_difficulty_bm);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pool_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_pre: pool_reset=%b want 0 (in run)", pool_reset);
        end
        #2 reset = 1'b1;
        #1;
        sb.delete();
        n_cmp++;
        if ({job_ready, pool_reset, result_valid, busy, result_found, result_cancelled} !== 6'b110000 ||
            {pool_sha_state, pool_difficulty_bm, pool_message_head, pool_nonce_start_MSB, result_nonce} !== '0) begin
            n_bad++;
            $display("FAIL areset_now: rdy/prst/rv/busy=%b bm=%h not at reset values",
                     {job_ready, pool_reset, result_valid, busy}, pool_difficulty_bm);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({job_ready, busy, result_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL areset_after: rdy/busy/rv=%b want 100", {job_ready, busy, result_valid});
        end
    endtask

    initial begin
        reset               = 1'b1;
        job_valid           = 1'b0;
        job_sha_state       = '0;
        job_message_head    = '0;
        job_difficulty_bm   = '0;
        job_nonce_start_MSB = '0;
        cancel              = 1'b0;
        pool_success        = 1'b0;
        pool_nonce          = '0;
        result_ready        = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_found();
        test_exhaust();
        test_cancel();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
